mux4_rr_arbiter: RTL and testbench
==================================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 4 (range 1..15): the maximum number of consecutive cycles one requester may own the mux.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 4 bits: req[i] requests mux channel i.
REQ-005 The block SHALL have port c, input, 4 bits: data bits c0..c3 (c[i] = channel i data).
REQ-006 The block SHALL have port gnt, output, 4 bits: registered one-hot grant, or all-zero when idle.
REQ-007 The block SHALL have port s1, output, 1 bit: registered mux select MSB.
REQ-008 The block SHALL have port s0, output, 1 bit: registered mux select LSB.
REQ-009 The block SHALL have port z, output, 1 bit: registered mux output.
REQ-010 The block SHALL have port z_valid, output, 1 bit: z carries data from the channel granted in the previous cycle.

Function
REQ-011 The FSM SHALL have two states: IDLE (gnt=0) and GRANT (exactly one gnt bit set).
REQ-012 IDLE -> GRANT SHALL occur when req != 0; the grant appears in the cycle after req is first sampled high (1-cycle latency).
REQ-013 Winner selection SHALL be round-robin: search starts at index (ptr+1) mod 4 and wraps; ptr = index of the last granted channel.
REQ-014 {s1,s0} SHALL equal the binary index of the granted channel, updated in the same cycle as gnt, and SHALL hold its last value in IDLE.
REQ-015 hold_cnt SHALL be 4 bits: cleared on each new grant, incremented each GRANT cycle, and saturating at MAX_HOLD.
REQ-016 Release SHALL occur when req[owner]=0 or hold_cnt reaches MAX_HOLD-1 in the current cycle.
REQ-017 On release with other requests pending, the next RR winner SHALL be granted in the next cycle with no IDLE gap.
REQ-018 On release when only the owner still requests (hold exhausted), the owner SHALL be re-granted and hold_cnt cleared.
REQ-019 On release with req == 0, the FSM SHALL go to IDLE.
REQ-020 Simultaneous requests SHALL be resolved by RR order only; no requester may be granted twice while another requester waits across its release.
REQ-021 z SHALL equal c[{s1,s0}] registered each cycle; z_valid SHALL equal (gnt != 0) delayed by one cycle.
REQ-022 Starvation bound: any held req SHALL be granted within 3*MAX_HOLD+1 cycles.

Reset
REQ-023 While rst=1 at a clock edge, outputs SHALL become gnt=0000, s1=0, s0=0, z=0, z_valid=0, and internal state SHALL become state=IDLE, hold_cnt=0, ptr=3 (channel 0 has first priority).
REQ-024 Reset asserted mid-grant SHALL abort the grant in the same edge, with no partial z_valid afterward.
REQ-025 In the first cycle after rst deasserts, the block SHALL behave as IDLE with the req value sampled then.

Structure
REQ-026 A shared package mux_arb_pkg SHALL hold the state encoding (IDLE=0, GRANT=1), the channel count constant NCH=4, and the MAX_HOLD default.
REQ-027 The block SHALL instantiate one sub-module mux4x1 (ports c0,c1,c2,c3,s1,s0,z; purely combinational) as its datapath, feeding the z register.
REQ-028 The RR winner search SHALL be a combinational function inside mux4_rr_arbiter; no further sub-modules are permitted.

Verification
REQ-029 A bench SHALL check: reset, then req=0001, c=0001 -> next cycle gnt=0001 and s1s0=00; following cycle z=1 and z_valid=1.
REQ-030 A bench SHALL check: req=1111 held with MAX_HOLD=4 -> grants 0001,0010,0100,1000,0001 repeating, each exactly 4 cycles with no gaps.
REQ-031 A bench SHALL check: owner 2 drops req after 2 cycles while req[0] is pending -> gnt=0001 in the next cycle, then hold_cnt restarts.
REQ-032 A bench SHALL check: only req[3] held for 10 cycles -> gnt stays 1000 throughout (re-grant at each hold expiry); z tracks c[3] with 1-cycle lag.
REQ-033 A bench SHALL check: rst pulsed during a grant to channel 1 -> next cycle gnt=0, s1s0=00, z=0, z_valid=0; after release with req=0110, channel 1 is granted first (ptr=3).
REQ-034 A bench SHALL check: req drops to 0000 during a grant -> IDLE next cycle with gnt=0 and s1s0 held; z_valid falls one cycle later.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 4-channel round-robin mux arbiter:
// FSM state encoding, channel count and default hold limit.
package mux_arb_pkg;

    localparam int NCH          = 4;
    localparam int MAX_HOLD_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/mux4_rr_arbiter_mux4x1.sv
// Purely combinational 4:1 bit mux; {s1,s0} selects the channel driven onto z.
module mux4x1 (
    input  logic c0,
    input  logic c1,
    input  logic c2,
    input  logic c3,
    input  logic s1,
    input  logic s0,
    output logic z
);

    always_comb begin
        z = c0;
        case ({s1, s0})
            2'b00:   z = c0;
            2'b01:   z = c1;
            2'b10:   z = c2;
            2'b11:   z = c3;
            default: z = c0;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning a 4:1 mux; each owner keeps the select for at most
// MAX_HOLD consecutive cycles, and the muxed bit is registered with a valid flag.
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] c,
    output logic [NCH-1:0] gnt,
    output logic           s1,
    output logic           s0,
    output logic           z,
    output logic           z_valid
);

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
    localparam logic [3:0] HOLD_SAT  = 4'(MAX_HOLD);

    // First requester strictly after 'last', wrapping; 'last' itself is tried last.
    function automatic logic [1:0] rr_pick(input logic [NCH-1:0] r, input logic [1:0] last);
        logic [1:0] idx;
        logic       found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            idx = last + 2'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    state_e         state_q, state_d;
    logic [NCH-1:0] gnt_q, gnt_d;
    logic [1:0]     sel_q, sel_d;
    logic [1:0]     ptr_q, ptr_d;
    logic [3:0]     hold_q, hold_d;
    logic           z_q, z_d;
    logic           zv_q, zv_d;
    logic           mux_z;
    logic [1:0]     winner;
    logic           release_now;

    mux4x1 u_mux (
        .c0 (c[0]),
        .c1 (c[1]),
        .c2 (c[2]),
        .c3 (c[3]),
        .s1 (sel_q[1]),
        .s0 (sel_q[0]),
        .z  (mux_z)
    );

    assign winner      = rr_pick(req, ptr_q);
    // While in GRANT the owner is always the channel recorded in ptr_q.
    assign release_now = (state_q == GRANT) && (!req[ptr_q] || (hold_q == HOLD_LAST));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        z_d     = mux_z;
        zv_d    = |gnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << winner;
                    sel_d   = winner;
                    ptr_d   = winner;
                    hold_d  = 4'd0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    if (|req) begin
                        gnt_d  = 4'b0001 << winner;
                        sel_d  = winner;
                        ptr_d  = winner;
                        hold_d = 4'd0;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd3;
            hold_q  <= 4'd0;
            z_q     <= 1'b0;
            zv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            z_q     <= z_d;
            zv_q    <= zv_d;
        end
    end

    assign gnt     = gnt_q;
    assign s1      = sel_q[1];
    assign s0      = sel_q[0];
    assign z       = z_q;
    assign z_valid = zv_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scenario bench for mux4_rr_arbiter: per-cycle expectations are queued as stimulus
// is applied and compared against {gnt, s1, s0, z, z_valid} after each edge.
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] c;
    logic [3:0] gnt;
    logic       s1, s0, z, z_valid;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sb [$];
    logic [1:0] m_sel = 2'd0;
    logic       m_gv  = 1'b0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .c       (c),
        .gnt     (gnt),
        .s1      (s1),
        .s0      (s0),
        .z       (z),
        .z_valid (z_valid)
    );

    // Expected outputs after the coming edge, given the grant that edge should produce.
    task automatic push_exp(input logic [3:0] g);
        logic [1:0] sel;
        logic       zz;
        if (rst) begin
            sb.push_back(8'h00);
            m_sel = 2'd0;
            m_gv  = 1'b0;
        end else begin
            zz = c[m_sel];
            case (g)
                4'b0001: sel = 2'd0;
                4'b0010: sel = 2'd1;
                4'b0100: sel = 2'd2;
                4'b1000: sel = 2'd3;
                default: sel = m_sel;
            endcase
            sb.push_back({g, sel, zz, m_gv});
            m_sel = sel;
            m_gv  = |g;
        end
    endtask

    task automatic test_reset();
        logic [3:0] rq [6] = '{4'b1111, 4'b1111, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
        logic [3:0] eg [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
        logic [7:0] e;
        for (int i = 0; i < 6; i++) begin
            rst = (i < 2); req = rq[i]; c = 4'($urandom);
            push_exp(eg[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if ({gnt, s1, s0, z, z_valid} !== e) begin
                n_fail++;
                $display("FAIL reset cyc%0d: got gnt=%b sel=%b%b z=%b zv=%b, want gnt=%b sel=%b z=%b zv=%b",
                         i, gnt, s1, s0, z, z_valid, e[7:4], e[3:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_single();
        logic [3:0] rq [5] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        logic [3:0] eg [5] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        logic [7:0] e;
        for (int i = 0; i < 5; i++) begin
            rst = (i == 0); req = rq[i]; c = 4'b0001;
            push_exp(eg[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if ({gnt, s1, s0, z, z_valid} !== e) begin
                n_fail++;
                $display("FAIL single cyc%0d: got gnt=%b sel=%b%b z=%b zv=%b, want gnt=%b sel=%b z=%b zv=%b",
                         i, gnt, s1, s0, z, z_valid, e[7:4], e[3:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] eg;
        logic [7:0] e;
        int         k;
        for (int i = 0; i < 22; i++) begin
            rst = (i == 0); req = (i == 21) ? 4'b0000 : 4'b1111; c = 4'($urandom);
            k  = ((i - 1) / 4) % 4;
            eg = (i == 0 || i == 21) ? 4'b0000 : 4'(4'b0001 << k);
            push_exp(eg);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if ({gnt, s1, s0, z, z_valid} !== e) begin
                n_fail++;
                $display("FAIL round_robin cyc%0d: got gnt=%b sel=%b%b z=%b zv=%b, want gnt=%b sel=%b z=%b zv=%b",
                         i, gnt, s1, s0, z, z_valid, e[7:4], e[3:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_drop_owner();
        logic [3:0] rq [9] = '{4'b0000, 4'b0100, 4'b0101, 4'b0001, 4'b1001,
                               4'b1001, 4'b1001, 4'b1001, 4'b0000};
        logic [3:0] eg [9] = '{4'b0000, 4'b0100, 4'b0100, 4'b0001, 4'b0001,
                               4'b0001, 4'b0001, 4'b1000, 4'b0000};
        logic [7:0] e;
        for (int i = 0; i < 9; i++) begin
            rst = (i == 0); req = rq[i]; c = 4'($urandom);
            push_exp(eg[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if ({gnt, s1, s0, z, z_valid} !== e) begin
                n_fail++;
                $display("FAIL drop_owner cyc%0d: got gnt=%b sel=%b%b z=%b zv=%b, want gnt=%b sel=%b z=%b zv=%b",
                         i, gnt, s1, s0, z, z_valid, e[7:4], e[3:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_only_ch3();
        logic [3:0] eg;
        logic [7:0] e;
        for (int i = 0; i < 13; i++) begin
            rst = (i == 0); req = (i >= 1 && i <= 10) ? 4'b1000 : 4'b0000; c = 4'($urandom);
            eg  = (i >= 1 && i <= 10) ? 4'b1000 : 4'b0000;
            push_exp(eg);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if ({gnt, s1, s0, z, z_valid} !== e) begin
                n_fail++;
                $display("FAIL only_ch3 cyc%0d: got gnt=%b sel=%b%b z=%b zv=%b, want gnt=%b sel=%b z=%b zv=%b",
                         i, gnt, s1, s0, z, z_valid, e[7:4], e[3:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        logic [3:0] rq [7] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0110, 4'b0110, 4'b0000};
        logic [3:0] eg [7] = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
        logic [7:0] e;
        for (int i = 0; i < 7; i++) begin
            rst = (i == 0 || i == 3); req = rq[i]; c = 4'($urandom);
            push_exp(eg[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if ({gnt, s1, s0, z, z_valid} !== e) begin
                n_fail++;
                $display("FAIL reset_mid_grant cyc%0d: got gnt=%b sel=%b%b z=%b zv=%b, want gnt=%b sel=%b z=%b zv=%b",
                         i, gnt, s1, s0, z, z_valid, e[7:4], e[3:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_drop_all();
        logic [3:0] rq [7] = '{4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
        logic [3:0] eg [7] = '{4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
        logic [7:0] e;
        for (int i = 0; i < 7; i++) begin
            rst = (i == 0); req = rq[i]; c = 4'($urandom);
            push_exp(eg[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if ({gnt, s1, s0, z, z_valid} !== e) begin
                n_fail++;
                $display("FAIL drop_all cyc%0d: got gnt=%b sel=%b%b z=%b zv=%b, want gnt=%b sel=%b z=%b zv=%b",
                         i, gnt, s1, s0, z, z_valid, e[7:4], e[3:2], e[1], e[0]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        c   = 4'b0000;
        test_reset();
        test_single();
        test_round_robin();
        test_drop_owner();
        test_only_ch3();
        test_reset_mid_grant();
        test_drop_all();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
